reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
- Parametrised bank of NREGS general-purpose registers, each WIDTH bits. Supersedes the fixed single-purpose 8-bit load registers (A, B, out, instruction).
- Each register is loaded from the shared bus or modified in place by a per-cycle operation: load, increment, decrement, shift or clear.
- Two independent combinational read ports feed the ALU and bus drivers.
- Registered zero and carry flags report the result of the most recent operation.

Parameters:
- WIDTH, 8, bit width of each register, the bus and the read ports; WIDTH >= 2.
- NREGS, 4, number of registers; 2 <= NREGS <= 16.
- SELW, $clog2(NREGS), width of the select fields; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  synchronous, active-high reset.
- bus  in  WIDTH  shared data bus; source operand for LOAD.
- we  in  1  operation enable; when 0, no register or flag changes.
- wsel  in  SELW  target register index.
- op  in  3  operation code; values listed under Behaviour.
- rsel_a  in  SELW  read port A register index.
- rsel_b  in  SELW  read port B register index.
- out_a  out  WIDTH  contents of register rsel_a.
- out_b  out  WIDTH  contents of register rsel_b.
- zf  out  1  zero flag; 1 when the last operation result was 0.
- cf  out  1  carry/borrow/shift-out flag of the last operation.

Behaviour:
- Reset: clr=1 at a rising edge sets all registers to 0, zf=0 and cf=0.
  - clr has priority over we/op in the same cycle.
  - clr asserted mid-sequence discards that cycle's operation.
  - While clr=1: out_a=0, out_b=0.
- Op codes (3'b):
  - 000 HOLD: no change; flags unchanged even if we=1.
  - 001 LOAD: reg <= bus; cf <= 0.
  - 010 INC: reg <= reg+1 mod 2^WIDTH; cf <= 1 only on wrap from all-ones to 0.
  - 011 DEC: reg <= reg-1 mod 2^WIDTH; cf <= 1 only on wrap from 0 to all-ones (borrow).
  - 100 SHL: reg <= {reg[WIDTH-2:0],1'b0}; cf <= old reg[WIDTH-1].
  - 101 SHR: reg <= {1'b0,reg[WIDTH-1:1]}; cf <= old reg[0].
  - 110 CLR: reg <= 0; cf <= 0.
  - 111 reserved: treated as HOLD.
- Flag rule: for every op except HOLD/reserved, with we=1 and valid wsel, zf <= (new register value == 0) in the same edge as the register update.
- Latency:
  - Register update and flags are visible one cycle after the enabling edge.
  - Read ports are combinational from current register state; no write-to-read bypass. A read of wsel in the same cycle as its write returns the old value.
- Out-of-range select (only possible when NREGS is not a power of two):
  - wsel >= NREGS: operation ignored; registers and flags unchanged.
  - rsel_x >= NREGS: out_x = 0.
- Only register wsel is modified per cycle; all others hold.
- rsel_a == rsel_b is legal; both ports return the same value.
- Not affected by op: the bus, read ports and flags of any register other than the one being updated.
- Single clock domain; no internal state other than the register array and two flag bits. Fully synthesisable; no latches; no tristates.

Decomposition:
- Shared package reg_bank_pkg holds the op-code localparams:
  - OP_HOLD, OP_LOAD, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_CLR.
  - OP_W = 3.
- Sub-module reg_bank_alu (combinational):
  - Inputs: old value, bus, op.
  - Outputs: next value, carry-out.
  - Instantiated once, on the wsel-selected register.
- Top-level reg_bank holds the register array, flags, write decode and read muxes.

Test Plan:
- Reset: preload r0..r3 = 8'h11,22,33,44 → clr=1 one cycle → all reads 0, zf=0, cf=0; simultaneous we=1/LOAD with clr → register stays 0.
- Load/read: LOAD bus=8'hA5 to r2, next cycle LOAD 8'h00 to r1 → out_a(rsel_a=2)=8'hA5, out_b(rsel_b=1)=0, zf=1, cf=0; same-cycle read of r2 during its write returns old value.
- INC wrap: r0=8'hFE, INC twice → 8'hFF (cf=0, zf=0) then 8'h00 (cf=1, zf=1); DEC from 0 → 8'hFF, cf=1, zf=0.
- Shifts: r3=8'h81, SHL → 8'h02, cf=1; SHR → 8'h01, cf=0; SHR → 8'h00, cf=1, zf=1.
- Enable/HOLD: we=0 with op=INC, or we=1 with op=HOLD/111 → registers and flags unchanged over 5 cycles; CLR op on r1=8'h7F → 0, zf=1, cf=0.
- Parameter sweep: WIDTH=16, NREGS=3 → wsel=3 INC ignored (flags unchanged), rsel_a=3 returns 0, INC of 16'hFFFF wraps to 0 with cf=1.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared op-code definitions for the general-purpose register bank.
package reg_bank_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_INC  = 3'b010;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b011;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b101;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b110;
    localparam logic [OP_W-1:0] OP_RSVD = 3'b111;
endpackage

// File: rtl/reg_bank_if.sv
// Bus, operation and read-port signals between the register bank and its user.
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
);
    localparam int SELW = $clog2(NREGS);

    logic [WIDTH-1:0] bus;
    logic             we;
    logic [SELW-1:0]  wsel;
    logic [OP_W-1:0]  op;
    logic [SELW-1:0]  rsel_a;
    logic [SELW-1:0]  rsel_b;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             zf;
    logic             cf;

    modport master (
        output bus, we, wsel, op, rsel_a, rsel_b,
        input  out_a, out_b, zf, cf
    );

    modport slave (
        input  bus, we, wsel, op, rsel_a, rsel_b,
        output out_a, out_b, zf, cf
    );
endinterface

// File: rtl/reg_bank_alu.sv
// Combinational next-value and carry logic for the register selected by wsel.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] bus,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] nxt,
    output logic             carry
);
    always_comb begin
        nxt   = cur;
        carry = 1'b0;
        case (op)
            OP_LOAD: nxt = bus;
            OP_INC: begin
                nxt   = cur + 1'b1;
                carry = &cur;
            end
            OP_DEC: begin
                nxt   = cur - 1'b1;
                carry = ~|cur;
            end
            OP_SHL: begin
                nxt   = {cur[WIDTH-2:0], 1'b0};
                carry = cur[WIDTH-1];
            end
            OP_SHR: begin
                nxt   = {1'b0, cur[WIDTH-1:1]};
                carry = cur[0];
            end
            OP_CLR: nxt = '0;
            default: begin
                nxt   = cur;
                carry = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/reg_bank.sv
// Register array with one in-place operation per cycle, two read ports and zero/carry flags.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input logic       clk,
    input logic       clr,
    reg_bank_if.slave rb
);
    localparam int SELW = $clog2(NREGS);
    localparam logic [SELW:0] NREGS_L = (SELW+1)'(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic             zero_flag;
    logic             carry_flag;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             carry;
    logic             op_active;
    logic             wsel_ok;
    logic             rsel_a_ok;
    logic             rsel_b_ok;

    function automatic logic in_range(input logic [SELW-1:0] sel);
        return {1'b0, sel} < NREGS_L;
    endfunction

    assign wsel_ok   = in_range(rb.wsel);
    assign rsel_a_ok = in_range(rb.rsel_a);
    assign rsel_b_ok = in_range(rb.rsel_b);
    assign op_active = (rb.op != OP_HOLD) && (rb.op != OP_RSVD);
    assign cur       = wsel_ok ? regs[rb.wsel] : '0;

    reg_bank_alu #(.WIDTH(WIDTH)) alu (
        .cur   (cur),
        .bus   (rb.bus),
        .op    (rb.op),
        .nxt   (nxt),
        .carry (carry)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (rb.we && wsel_ok && op_active) begin
            regs[rb.wsel] <= nxt;
            zero_flag     <= (nxt == '0);
            carry_flag    <= carry;
        end
    end

    // Read ports are forced to zero while clr is held so no stale data leaks out.
    assign rb.out_a = (clr || !rsel_a_ok) ? '0 : regs[rb.rsel_a];
    assign rb.out_b = (clr || !rsel_b_ok) ? '0 : regs[rb.rsel_b];
    assign rb.zf    = zero_flag;
    assign rb.cf    = carry_flag;
endmodule

// File: tb/tb_reg_bank.sv
// Directed vector bench for reg_bank: an 8-bit/4-register and a 16-bit/3-register instance.
module tb_reg_bank;
    import reg_bank_pkg::*;

    typedef struct {
        logic        clr;
        logic        we;
        logic [3:0]  wsel;
        logic [2:0]  op;
        logic [15:0] bus;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ezf;
        logic        ecf;
    } vec_t;

    logic clk = 1'b0;
    logic clr8 = 1'b1;
    logic clr16 = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_bank_if #(.WIDTH(8),  .NREGS(4)) if8();
    reg_bank_if #(.WIDTH(16), .NREGS(3)) if16();

    reg_bank #(.WIDTH(8),  .NREGS(4)) dut8  (.clk(clk), .clr(clr8),  .rb(if8));
    reg_bank #(.WIDTH(16), .NREGS(3)) dut16 (.clk(clk), .clr(clr16), .rb(if16));

    vec_t v8[$];
    vec_t v16[$];

    function automatic vec_t mk(input logic c, input logic w, input logic [3:0] ws,
                                input logic [2:0] o, input logic [15:0] b,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic ezf, input logic ecf);
        vec_t v;
        v.clr = c; v.we = w; v.wsel = ws; v.op = o; v.bus = b;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.ezf = ezf; v.ecf = ecf;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input bit wide);
        if (wide) begin
            clr16 = v.clr; if16.we = v.we; if16.wsel = v.wsel[1:0]; if16.op = v.op;
            if16.bus = v.bus; if16.rsel_a = v.ra[1:0]; if16.rsel_b = v.rb[1:0];
        end else begin
            clr8 = v.clr; if8.we = v.we; if8.wsel = v.wsel[1:0]; if8.op = v.op;
            if8.bus = v.bus[7:0]; if8.rsel_a = v.ra[1:0]; if8.rsel_b = v.rb[1:0];
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx, input bit wide);
        string tag;
        tag = $sformatf("%s[%0d]", wide ? "w16" : "w8", idx);
        @(negedge clk);
        drive(v, wide);
        @(posedge clk);
        #1;
        if (wide) begin
            check({tag, ".out_a"}, if16.out_a, v.ea);
            check({tag, ".out_b"}, if16.out_b, v.eb);
            check({tag, ".zf"}, {15'd0, if16.zf}, {15'd0, v.ezf});
            check({tag, ".cf"}, {15'd0, if16.cf}, {15'd0, v.ecf});
        end else begin
            check({tag, ".out_a"}, {8'd0, if8.out_a}, v.ea);
            check({tag, ".out_b"}, {8'd0, if8.out_b}, v.eb);
            check({tag, ".zf"}, {15'd0, if8.zf}, {15'd0, v.ezf});
            check({tag, ".cf"}, {15'd0, if8.cf}, {15'd0, v.ecf});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if8.we = 0;  if8.wsel = 0;  if8.op = OP_HOLD;  if8.bus = 0;  if8.rsel_a = 0;  if8.rsel_b = 0;
        if16.we = 0; if16.wsel = 0; if16.op = OP_HOLD; if16.bus = 0; if16.rsel_a = 0; if16.rsel_b = 0;

        // clr we ws op bus ra rb ea eb zf cf
        v8.push_back(mk(1, 0, 0, OP_HOLD, 16'h00, 0, 0, 16'h00, 16'h00, 0, 0));
        v8.push_back(mk(0, 1, 0, OP_LOAD, 16'h11, 0, 0, 16'h11, 16'h11, 0, 0));
        v8.push_back(mk(0, 1, 1, OP_LOAD, 16'h22, 1, 0, 16'h22, 16'h11, 0, 0));
        v8.push_back(mk(0, 1, 2, OP_LOAD, 16'h33, 2, 1, 16'h33, 16'h22, 0, 0));
        v8.push_back(mk(0, 1, 3, OP_LOAD, 16'h44, 3, 2, 16'h44, 16'h33, 0, 0));
        v8.push_back(mk(1, 1, 0, OP_LOAD, 16'hFF, 0, 3, 16'h00, 16'h00, 0, 0));
        v8.push_back(mk(0, 0, 0, OP_HOLD, 16'h00, 0, 3, 16'h00, 16'h00, 0, 0));
        v8.push_back(mk(0, 0, 0, OP_HOLD, 16'h00, 1, 2, 16'h00, 16'h00, 0, 0));
        v8.push_back(mk(0, 1, 2, OP_LOAD, 16'hA5, 2, 1, 16'hA5, 16'h00, 0, 0));
        v8.push_back(mk(0, 1, 1, OP_LOAD, 16'h00, 2, 1, 16'hA5, 16'h00, 1, 0));
        v8.push_back(mk(0, 1, 0, OP_LOAD, 16'hFE, 0, 2, 16'hFE, 16'hA5, 0, 0));
        v8.push_back(mk(0, 1, 0, OP_INC,  16'h00, 0, 2, 16'hFF, 16'hA5, 0, 0));
        v8.push_back(mk(0, 1, 0, OP_INC,  16'h00, 0, 2, 16'h00, 16'hA5, 1, 1));
        v8.push_back(mk(0, 1, 0, OP_DEC,  16'h00, 0, 2, 16'hFF, 16'hA5, 0, 1));
        v8.push_back(mk(0, 1, 3, OP_LOAD, 16'h81, 3, 0, 16'h81, 16'hFF, 0, 0));
        v8.push_back(mk(0, 1, 3, OP_SHL,  16'h00, 3, 0, 16'h02, 16'hFF, 0, 1));
        v8.push_back(mk(0, 1, 3, OP_SHR,  16'h00, 3, 0, 16'h01, 16'hFF, 0, 0));
        v8.push_back(mk(0, 1, 3, OP_SHR,  16'h00, 3, 0, 16'h00, 16'hFF, 1, 1));
        v8.push_back(mk(0, 0, 0, OP_INC,  16'h00, 0, 3, 16'hFF, 16'h00, 1, 1));
        v8.push_back(mk(0, 1, 0, OP_HOLD, 16'h00, 0, 3, 16'hFF, 16'h00, 1, 1));
        v8.push_back(mk(0, 1, 0, OP_RSVD, 16'h00, 0, 3, 16'hFF, 16'h00, 1, 1));
        v8.push_back(mk(0, 0, 3, OP_LOAD, 16'h55, 0, 3, 16'hFF, 16'h00, 1, 1));
        v8.push_back(mk(0, 1, 3, OP_RSVD, 16'h55, 0, 3, 16'hFF, 16'h00, 1, 1));
        v8.push_back(mk(0, 1, 1, OP_LOAD, 16'h7F, 1, 0, 16'h7F, 16'hFF, 0, 0));
        v8.push_back(mk(0, 1, 0, OP_INC,  16'h00, 1, 0, 16'h7F, 16'h00, 1, 1));
        v8.push_back(mk(0, 1, 1, OP_CLR,  16'h00, 1, 0, 16'h00, 16'h00, 1, 0));
        v8.push_back(mk(0, 1, 2, OP_LOAD, 16'h10, 2, 2, 16'h10, 16'h10, 0, 0));
        v8.push_back(mk(0, 1, 2, OP_DEC,  16'h00, 2, 2, 16'h0F, 16'h0F, 0, 0));
        v8.push_back(mk(0, 0, 0, OP_HOLD, 16'h00, 0, 3, 16'h00, 16'h00, 0, 0));

        v16.push_back(mk(1, 0, 0, OP_HOLD, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0));
        v16.push_back(mk(0, 1, 0, OP_LOAD, 16'hFFFF, 0, 1, 16'hFFFF, 16'h0000, 0, 0));
        v16.push_back(mk(0, 1, 2, OP_LOAD, 16'h1234, 2, 0, 16'h1234, 16'hFFFF, 0, 0));
        v16.push_back(mk(0, 1, 0, OP_INC,  16'h0000, 0, 2, 16'h0000, 16'h1234, 1, 1));
        v16.push_back(mk(0, 1, 3, OP_INC,  16'h0000, 3, 2, 16'h0000, 16'h1234, 1, 1));
        v16.push_back(mk(0, 1, 3, OP_LOAD, 16'h00FF, 0, 2, 16'h0000, 16'h1234, 1, 1));
        v16.push_back(mk(0, 1, 2, OP_SHL,  16'h0000, 2, 3, 16'h2468, 16'h0000, 0, 0));

        foreach (v8[i]) run_vec(v8[i], i, 1'b0);

        // Write to r2 while reading it: old value before the edge, new value after.
        @(negedge clk);
        if8.we = 1; if8.wsel = 2; if8.op = OP_LOAD; if8.bus = 8'h3C; if8.rsel_a = 2; if8.rsel_b = 2;
        #1;
        check("same_cycle_read_old", {8'd0, if8.out_a}, 16'h000F);
        @(posedge clk);
        #1;
        check("same_cycle_read_new", {8'd0, if8.out_a}, 16'h003C);

        // Read ports are zero while clr is high, before the clearing edge.
        @(negedge clk);
        if8.we = 0; clr8 = 1;
        #1;
        check("clr_high_out_a", {8'd0, if8.out_a}, 16'h0000);
        check("clr_high_out_b", {8'd0, if8.out_b}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        clr8 = 0;
        #1;
        check("after_clr_r2", {8'd0, if8.out_a}, 16'h0000);
        check("after_clr_zf", {15'd0, if8.zf}, 16'h0000);

        @(negedge clk);
        clr16 = 0;
        foreach (v16[i]) run_vec(v16[i], i, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
